// File: rtl/stopwatch_pkg.sv
// Shared types and limits for the stopwatch controller.
// Field widths, wrap limits and the load clamp helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_t;

    localparam int CENTI_W = 7;
    localparam int SEC_W   = 6;
    localparam int MIN_W   = 6;

    localparam logic [CENTI_W-1:0] CENTI_MAX = 7'd99;
    localparam logic [SEC_W-1:0]   SEC_MAX   = 6'd59;
    localparam logic [MIN_W-1:0]   MIN_MAX   = 6'd59;

    function automatic logic [5:0] clamp6(
        input logic [5:0] v,
        input logic [5:0] lim
    );
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-K up counter with clear, parallel load and enable.
// Carry flags the enabled cycle on which the counter wraps.
module mod_counter #(
    parameter int N = 8,
    parameter int K = 256
) (
    input  logic         Clock,
    input  logic         Reset_n,
    input  logic         En,
    input  logic         Clr,
    input  logic         Ld,
    input  logic [N-1:0] D,
    output logic [N-1:0] Q,
    output logic         Carry
);

    localparam logic [N-1:0] TOP = N'(K - 1);

    assign Carry = En && (Q == TOP);

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            Q <= '0;
        end else if (Clr) begin
            Q <= '0;
        end else if (Ld) begin
            Q <= D;
        end else if (En) begin
            Q <= Carry ? '0 : Q + N'(1);
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/pause/clear/load FSM driving a
// prescaler and a centi/sec/min modulo counter cascade.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int PRESCALE = 500000,
    parameter int PW       = 19
) (
    input  logic               Clock,
    input  logic               Reset_n,
    input  logic               Start_Stop,
    input  logic               Clear,
    input  logic               Load,
    input  logic [MIN_W-1:0]   Load_Min,
    input  logic [SEC_W-1:0]   Load_Sec,
    output logic               Running,
    output logic [CENTI_W-1:0] Centi,
    output logic [SEC_W-1:0]   Sec,
    output logic [MIN_W-1:0]   Min,
    output logic               Wrap
);

    sw_state_t state;

    logic          run;
    logic          load_ok;
    logic          ss_cmd;
    logic          tick;
    logic          centi_carry;
    logic          sec_carry;
    logic          min_carry;
    logic          psc_clr;
    logic          time_clr;
    logic [PW-1:0] psc_q;

    logic [SEC_W-1:0] sec_d;
    logic [MIN_W-1:0] min_d;

    // Commands decoded to be mutually exclusive: Clear > Load > Start_Stop.
    assign run     = (state == ST_RUN);
    assign load_ok = Load && !Clear && (state != ST_RUN);
    assign ss_cmd  = Start_Stop && !Clear && !load_ok;

    assign sec_d = clamp6(Load_Sec, SEC_MAX);
    assign min_d = clamp6(Load_Min, MIN_MAX);

    assign psc_clr  = Clear || load_ok
                   || ((state == ST_IDLE) && (psc_q != '0));
    assign time_clr = Clear;

    mod_counter #(
        .N (PW),
        .K (PRESCALE)
    ) u_psc (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .En      (run),
        .Clr     (psc_clr),
        .Ld      (1'b0),
        .D       ('0),
        .Q       (psc_q),
        .Carry   (tick)
    );

    // Centi is zeroed on load; Sec/Min take the clamped presets.
    mod_counter #(
        .N (CENTI_W),
        .K (int'(CENTI_MAX) + 1)
    ) u_centi (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .En      (tick),
        .Clr     (time_clr || load_ok),
        .Ld      (1'b0),
        .D       ('0),
        .Q       (Centi),
        .Carry   (centi_carry)
    );

    mod_counter #(
        .N (SEC_W),
        .K (int'(SEC_MAX) + 1)
    ) u_sec (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .En      (centi_carry),
        .Clr     (time_clr),
        .Ld      (load_ok),
        .D       (sec_d),
        .Q       (Sec),
        .Carry   (sec_carry)
    );

    mod_counter #(
        .N (MIN_W),
        .K (int'(MIN_MAX) + 1)
    ) u_min (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .En      (sec_carry),
        .Clr     (time_clr),
        .Ld      (load_ok),
        .D       (min_d),
        .Q       (Min),
        .Carry   (min_carry)
    );

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state   <= ST_IDLE;
            Running <= 1'b0;
            Wrap    <= 1'b0;
        end else begin
            Wrap <= min_carry && !Clear;
            unique case (1'b1)
                Clear: begin
                    state   <= ST_IDLE;
                    Running <= 1'b0;
                end
                load_ok: begin
                    state   <= ST_PAUSE;
                    Running <= 1'b0;
                end
                ss_cmd: begin
                    if (state == ST_RUN) begin
                        state   <= ST_PAUSE;
                        Running <= 1'b0;
                    end else begin
                        state   <= ST_RUN;
                        Running <= 1'b1;
                    end
                end
                default: begin
                    state   <= state;
                    Running <= run;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with a short prescale
// so that whole-minute wraps fit in a few hundred cycles.
module tb_stopwatch_ctrl;

    logic       Clock = 1'b0;
    logic       Reset_n;
    logic       Start_Stop;
    logic       Clear;
    logic       Load;
    logic [5:0] Load_Min;
    logic [5:0] Load_Sec;
    logic       Running;
    logic [6:0] Centi;
    logic [5:0] Sec;
    logic [5:0] Min;
    logic       Wrap;

    int n_chk  = 0;
    int n_fail = 0;
    int wrap_cnt;

    always #5 Clock = ~Clock;

    stopwatch_ctrl #(
        .PRESCALE (4),
        .PW       (3)
    ) dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .Start_Stop (Start_Stop),
        .Clear      (Clear),
        .Load       (Load),
        .Load_Min   (Load_Min),
        .Load_Sec   (Load_Sec),
        .Running    (Running),
        .Centi      (Centi),
        .Sec        (Sec),
        .Min        (Min),
        .Wrap       (Wrap)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic chk_time(input string tag, input int m, input int s,
                            input int c);
        chk({tag, "_min"}, int'(Min), m);
        chk({tag, "_sec"}, int'(Sec), s);
        chk({tag, "_centi"}, int'(Centi), c);
    endtask

    task automatic pulse_ss();
        Start_Stop = 1'b1;
        step(1);
        Start_Stop = 1'b0;
    endtask

    task automatic pulse_load(input int m, input int s);
        Load     = 1'b1;
        Load_Min = 6'(m);
        Load_Sec = 6'(s);
        step(1);
        Load = 1'b0;
    endtask

    initial begin
        Reset_n    = 1'b0;
        Start_Stop = 1'b0;
        Clear      = 1'b0;
        Load       = 1'b0;
        Load_Min   = '0;
        Load_Sec   = '0;

        // Reset state
        step(2);
        chk_time("rst", 0, 0, 0);
        chk("rst_running", int'(Running), 0);
        chk("rst_wrap", int'(Wrap), 0);

        // First tick
        Reset_n = 1'b1;
        pulse_ss();
        chk("start_running", int'(Running), 1);
        chk("start_centi", int'(Centi), 0);
        step(3);
        chk("pre_tick_centi", int'(Centi), 0);
        step(1);
        chk("first_tick_centi", int'(Centi), 1);
        step(96);
        chk("centi_100cyc", int'(Centi), 25);

        // Cycle-exact pause: two RUN cycles into the hundredth
        step(1);
        pulse_ss();
        chk("pause_running", int'(Running), 0);
        chk("pause_centi0", int'(Centi), 25);
        step(5);
        chk("pause_centi5", int'(Centi), 25);
        step(5);
        chk("pause_centi10", int'(Centi), 25);
        pulse_ss();
        chk("resume_running", int'(Running), 1);
        chk("resume_centi", int'(Centi), 25);
        step(1);
        chk("resume_1cyc", int'(Centi), 25);
        step(1);
        chk("resume_2cyc", int'(Centi), 26);

        // Load clamping in PAUSE, load ignored in RUN
        pulse_ss();
        pulse_load(63, 60);
        chk_time("ld_clamp", 59, 59, 0);
        chk("ld_clamp_running", int'(Running), 0);
        pulse_ss();
        pulse_load(1, 2);
        chk_time("ld_in_run", 59, 59, 0);
        chk("ld_in_run_running", int'(Running), 1);

        // Priority: Clear + Load + Start_Stop in PAUSE
        pulse_ss();
        chk("prio_pre_running", int'(Running), 0);
        Clear = 1'b1;
        Start_Stop = 1'b1;
        pulse_load(5, 6);
        Clear = 1'b0;
        Start_Stop = 1'b0;
        chk_time("prio_clear", 0, 0, 0);
        chk("prio_clear_running", int'(Running), 0);

        // Load + Start_Stop in IDLE -> PAUSE with presets
        Start_Stop = 1'b1;
        pulse_load(59, 59);
        Start_Stop = 1'b0;
        chk_time("ld_ss_idle", 59, 59, 0);
        chk("ld_ss_idle_running", int'(Running), 0);

        // Wrap at 59:59.99 -> 00:00.00
        pulse_ss();
        wrap_cnt = 0;
        for (int i = 0; i < 399; i++) begin
            step(1);
            if (Wrap) wrap_cnt++;
        end
        chk_time("pre_wrap", 59, 59, 99);
        step(1);
        if (Wrap) wrap_cnt++;
        chk_time("wrap", 0, 0, 0);
        chk("wrap_pulse", int'(Wrap), 1);
        chk("wrap_running", int'(Running), 1);
        step(1);
        if (Wrap) wrap_cnt++;
        chk("wrap_after", int'(Wrap), 0);
        chk("wrap_once", wrap_cnt, 1);

        // Reset mid-count at 01:23.45
        Clear = 1'b1;
        step(1);
        Clear = 1'b0;
        pulse_load(1, 23);
        pulse_ss();
        step(180);
        chk_time("mid", 1, 23, 45);
        Reset_n = 1'b0;
        Start_Stop = 1'b1;
        step(1);
        Start_Stop = 1'b0;
        chk_time("mid_rst", 0, 0, 0);
        chk("mid_rst_running", int'(Running), 0);
        chk("mid_rst_wrap", int'(Wrap), 0);
        Reset_n = 1'b1;
        pulse_ss();
        chk("restart_running", int'(Running), 1);
        chk_time("restart", 0, 0, 0);
        step(4);
        chk_time("restart_tick", 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Stopwatch controller that sequences a cascade of modulo counters: a prescaler generates a 100 Hz tick that advances hundredths (0–99), seconds (0–59) and minutes (0–59). A start/stop/clear/load state machine drives it from pre-debounced single-cycle button pulses. It sits between the board input conditioning and the seven-segment display decoders. The time registers wrap from 59:59.99 to 00:00.00.

## Interface

**Parameters**
- PRESCALE, 500000 – clock cycles per hundredth (50 MHz / 100 Hz); legal range is 2 or more.
- PW, 19 – prescaler width; must satisfy 2^PW ≥ PRESCALE.

**Ports**
- Clock, input, 1 – single system clock; all logic on the rising edge.
- Reset_n, input, 1 – synchronous, active-low reset.
- Start_Stop, input, 1 – one-cycle pulse that toggles between run and pause.
- Clear, input, 1 – one-cycle pulse that zeroes the time and stops.
- Load, input, 1 – one-cycle pulse that loads Load_Min/Load_Sec.
- Load_Min, input, 6 – minute preset.
- Load_Sec, input, 6 – second preset.
- Running, output, 1 – high in RUN.
- Centi, output, 7 – hundredths, 0–99.
- Sec, output, 6 – seconds, 0–59.
- Min, output, 6 – minutes, 0–59.
- Wrap, output, 1 – one-cycle pulse on the 59:59.99 → 00:00.00 transition.

## Operation

- **States:**
  - IDLE: time zero, stopped.
  - RUN: counting.
  - PAUSE: stopped, time held.
- **Command priority per cycle:** Reset_n low > Clear > Load > Start_Stop.
- **Reset_n low at an edge:**
  - State becomes IDLE.
  - Centi, Sec, Min and the prescaler become 0.
  - Running and Wrap become 0.
  - This holds regardless of any other input, mid-count included.
- **Clear (any state):** state becomes IDLE; time and prescaler become 0; Wrap becomes 0.
- **Load:**
  - Honoured only in IDLE or PAUSE.
  - Sec ← min(Load_Sec, 59), Min ← min(Load_Min, 59), Centi ← 0, prescaler ← 0.
  - Next state is PAUSE.
  - Load in RUN is ignored entirely, and RUN continues.
  - A Start_Stop pulse in the same cycle as an honoured Load is dropped.
- **Start_Stop transitions:**
  - IDLE → RUN.
  - RUN → PAUSE.
  - PAUSE → RUN.
- **Prescaler:**
  - Counts only in RUN.
  - Retains its value in PAUSE, so the fractional hundredth is preserved across a pause.
  - Cleared in IDLE.
  - Tick is combinational: RUN and prescaler == PRESCALE−1.
  - On tick the prescaler returns to 0.
- **Cascade:**
  - Centi increments on tick.
  - Sec increments on tick when Centi == 99.
  - Min increments on tick when Centi == 99 and Sec == 59.
  - Each field wraps to 0 at its limit.
  - All carries are resolved combinationally, so every field updates on the same edge.
- **Wrap:** set to 1 on the edge where 59:59.99 advances to 00:00.00, 0 on all other edges. Counting continues; there is no auto-stop.

## Timing

- Running is registered and equals (state == RUN).
- The first Centi increment occurs exactly PRESCALE edges after the edge that entered RUN from IDLE.
- Subsequent increments occur every PRESCALE edges.
- Pause/resume is cycle-exact: the total RUN cycles between increments always equals PRESCALE.
- Clear, Load and Start_Stop take effect on the edge where they are sampled high. Outputs reflect the change in the following cycle.
- A tick coinciding with Start_Stop in RUN still increments; the state goes to PAUSE on that same edge.
- A tick coinciding with Clear is discarded; Clear wins.
- Input pulses longer than one cycle are not filtered; each high cycle is a command. The upstream debouncer guarantees single-cycle pulses.

## Structure

- **stopwatch_pkg** holds:
  - the state encoding (IDLE, RUN, PAUSE);
  - the limits CENTI_MAX = 99 and SEC_MAX = MIN_MAX = 59;
  - the field widths 7/6/6.
- **mod_counter** is the natural sub-module, instantiated four times (prescaler, Centi, Sec, Min). It has:
  - parameters N (width) and K (modulus);
  - inputs Clock, Reset_n (sync), En, Clr, Ld, D;
  - outputs Q and Carry (combinational, En && Q == K−1).
- The FSM and the load clamps live in stopwatch_ctrl.

## Test plan

- **First tick.** PRESCALE = 4; Reset_n low for 2 cycles, then Start_Stop. Required:
  - Running = 1 the next cycle.
  - Centi = 1 exactly 4 cycles after RUN entry, and Centi = 25 after 100 cycles.
- **Cycle-exact pause.** PRESCALE = 4; pause 2 cycles into a hundredth, hold 10 cycles, then resume. Required:
  - Centi unchanged throughout the pause.
  - Next increment exactly 2 RUN cycles after resume.
- **Wrap.** Load Min = 59, Sec = 59 in IDLE (state becomes PAUSE), then Start_Stop. Required:
  - After 100 ticks, time reads 00:00.00.
  - Wrap is high for exactly one cycle at the 59:59.99 → 00:00.00 transition.
  - Running stays 1.
- **Load clamping and gating.** Load with Load_Min = 63, Load_Sec = 60 in PAUSE → reads 59:59.00. Load asserted in RUN → no change, still running.
- **Priority.** Clear, Load and Start_Stop asserted together in PAUSE → IDLE, all zero, Running = 0. Load and Start_Stop together in IDLE → PAUSE with the loaded values.
- **Reset mid-count.** Reset_n driven low while RUN at 01:23.45 → next cycle all outputs 0 and state IDLE. A later Start_Stop restarts from 00:00.00.
